// File: rtl/column_output_drain.sv
// Column output drain: counts an accumulation window, then shifts, saturates and queues the column result.
// Optional macro DRAIN_RELU_EN clamps negative accumulator values to zero before shifting.
module column_output_drain #(
  parameter int ACC_LEN    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              shift_amt,
  input  logic signed [27:0]      acc_in,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    sat_flag,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic signed [27:0] SAT_MAX = (28'sd1 <<< (OUT_W - 1)) - 28'sd1;
  localparam logic signed [27:0] SAT_MIN = -(28'sd1 <<< (OUT_W - 1));
  localparam logic [7:0]         LAST_CNT = 8'(ACC_LEN - 1);
  localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE} state_t;

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic signed [27:0] relu_val;
  logic signed [27:0] shifted;
  logic [OUT_W-1:0]   result;
  logic               clamp;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, full, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // start is only looked at in IDLE and CAPTURE; a pulse mid-window is ignored
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == LAST_CNT) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        cnt_nxt = '0;
        state_nxt = start ? COUNT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef DRAIN_RELU_EN
    relu_val = acc_in[27] ? '0 : acc_in;
`else
    relu_val = acc_in;
`endif
    shifted = relu_val >>> shift_amt;
    clamp   = 1'b0;
    result  = OUT_W'(shifted);
    if (shifted > SAT_MAX) begin
      result = OUT_W'(SAT_MAX);
      clamp  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      result = OUT_W'(SAT_MIN);
      clamp  = 1'b1;
    end
  end

  assign push   = (state == CAPTURE);
  assign pop    = out_valid && out_ready;
  assign full   = (count == FULL_CNT);
  assign accept = push && (!full || pop);

  // A push into a full FIFO is still taken when a pop frees a slot the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= push && clamp;
      if (push && !accept) overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= result;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_column_output_drain.sv
// Directed bench for column_output_drain: latency, saturation, FIFO limits, reset and ignored start.
// Expectations for the negative cases follow DRAIN_RELU_EN when it is defined.
module tb_column_output_drain;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  shift_amt;
  logic [27:0] acc_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        sat_flag;
  logic        overflow;

  int num_checks = 0;
  int num_fails  = 0;

  column_output_drain #(.ACC_LEN(16), .FIFO_DEPTH(4), .OUT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_amt (shift_amt),
    .acc_in    (acc_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .sat_flag  (sat_flag),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Start edge plus 16 counting edges; returns during the CAPTURE cycle
  task automatic applyStimulus(input logic [27:0] acc, input logic [3:0] shift);
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_in = acc;
    shift_amt = shift;
    repeat (16) tick();
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_neg;
    logic        exp_neg_sat;
    logic [15:0] exp_neg_shift;
    int          seen;
`ifdef DRAIN_RELU_EN
    exp_neg       = 16'h0000;
    exp_neg_sat   = 1'b0;
    exp_neg_shift = 16'h0000;
`else
    exp_neg       = 16'h8000;
    exp_neg_sat   = 1'b1;
    exp_neg_shift = 16'hFFF0;
`endif
    reset = 1'b0;
    start = 1'b0;
    shift_amt = 4'd0;
    acc_in = '0;
    out_ready = 1'b0;
    #3;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_sat", sat_flag, 0);
    checkOutput("reset_ovf", overflow, 0);
    tick();
    reset = 1'b1;

    applyStimulus(28'h0000123, 4'd0);
    checkOutput("lat_capture_busy", busy, 1);
    checkOutput("lat_capture_valid", out_valid, 0);
    tick();
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_data", out_data, 16'h0123);
    checkOutput("lat_sat", sat_flag, 0);
    checkOutput("lat_idle", busy, 0);
    popOne();
    checkOutput("lat_popped", out_valid, 0);

    applyStimulus(28'h0100000, 4'd2);
    tick();
    checkOutput("satpos_data", out_data, 16'h7FFF);
    checkOutput("satpos_flag", sat_flag, 1);
    tick();
    checkOutput("satpos_flag_drop", sat_flag, 0);
    popOne();

    applyStimulus(28'h0007FFF, 4'd0);
    tick();
    checkOutput("edge_max_data", out_data, 16'h7FFF);
    checkOutput("edge_max_sat", sat_flag, 0);
    popOne();

    applyStimulus(28'hF000000, 4'd0);
    tick();
    checkOutput("satneg_data", out_data, exp_neg);
    checkOutput("satneg_flag", sat_flag, exp_neg_sat);
    popOne();

    applyStimulus(28'hFFFFF00, 4'd4);
    tick();
    checkOutput("negshift_data", out_data, exp_neg_shift);
    checkOutput("negshift_sat", sat_flag, 0);
    popOne();

    // Five chained windows with no reader: the fifth result is dropped
    for (int k = 1; k <= 4; k++) applyStimulus(28'(k), 4'd0);
    applyStimulus(28'd5, 4'd0);
    checkOutput("fill_ovf_before", overflow, 0);
    tick();
    checkOutput("fill_ovf_after", overflow, 1);
    checkOutput("fill_head", out_data, 1);
    checkOutput("fill_idle", busy, 0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("fill_drain_%0d", k), out_data, 16'(k));
      tick();
    end
    out_ready = 1'b0;
    checkOutput("fill_empty", out_valid, 0);
    checkOutput("ovf_sticky", overflow, 1);

    reset = 1'b0;
    #1;
    checkOutput("rst_clears_ovf", overflow, 0);
    tick();
    reset = 1'b1;

    for (int k = 11; k <= 14; k++) applyStimulus(28'(k), 4'd0);
    applyStimulus(28'd15, 4'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("fullpp_ovf", overflow, 0);
    checkOutput("fullpp_head", out_data, 12);
    out_ready = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      checkOutput($sformatf("fullpp_drain_%0d", k), out_data, 16'(k));
      tick();
    end
    out_ready = 1'b0;
    checkOutput("fullpp_empty", out_valid, 0);

    acc_in = 28'h0000077;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_valid", out_valid, 0);
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (24) begin
      tick();
      if (out_valid || busy) seen++;
    end
    checkOutput("midrst_no_result", seen, 0);

    acc_in = 28'h0000055;
    shift_amt = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkOutput("ign_capture_valid", out_valid, 0);
    tick();
    checkOutput("ign_valid", out_valid, 1);
    checkOutput("ign_data", out_data, 16'h0055);
    popOne();
    seen = 0;
    repeat (24) begin
      tick();
      if (out_valid || busy) seen++;
    end
    checkOutput("ign_single", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/column_output_drain.md
COLUMN_OUTPUT_DRAIN -- requirements
Module: column_output_drain

Interface
REQ-001 SHALL have parameter ACC_LEN, default 16, accumulation cycles per result (range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter OUT_W, default 16, output result width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins one accumulation window.
REQ-007 shift_amt  in  4  arithmetic right-shift applied to the captured sum.
REQ-008 acc_in  in  28  signed column accumulator value, driven from the column's total_output.
REQ-009 out_data  out  OUT_W  signed result at the FIFO head.
REQ-010 out_valid  out  1  FIFO non-empty.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 busy  out  1  high when state is not IDLE.
REQ-013 sat_flag  out  1  one-cycle pulse when a captured result saturated.
REQ-014 overflow  out  1  sticky; a result was dropped because the FIFO was full.

Function
REQ-015 FSM SHALL have the states IDLE, COUNT and CAPTURE.
REQ-016 In IDLE, start=1 SHALL move the FSM to COUNT with the 8-bit cycle counter cleared to 0.
REQ-017 In COUNT, the counter SHALL increment each cycle; at counter==ACC_LEN-1 the FSM SHALL move to CAPTURE.
REQ-018 In COUNT, start SHALL be ignored.
REQ-019 CAPTURE SHALL last exactly one cycle and sample acc_in in that cycle.
REQ-020 From CAPTURE, start=1 SHALL go to COUNT with the counter cleared; otherwise the FSM SHALL go to IDLE.
REQ-021 Result SHALL be computed as: acc_in treated as signed 28-bit, arithmetic right shift by shift_amt, then saturation to signed OUT_W.
REQ-022 Saturation bounds SHALL be -2^(OUT_W-1) and 2^(OUT_W-1)-1.
REQ-023 sat_flag SHALL pulse in the cycle after CAPTURE when clamping occurred.
REQ-024 The result SHALL be pushed into the FIFO at the end of the CAPTURE cycle.
REQ-025 If the FIFO is full and no pop occurs in that cycle, the result SHALL be dropped and overflow set.
REQ-026 Pop SHALL occur when out_valid and out_ready are both high.
REQ-027 A simultaneous push and pop on a full FIFO SHALL accept the push, with occupancy unchanged.
REQ-028 On an empty FIFO, a push SHALL raise out_valid on the next cycle.
REQ-029 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Latency: with start at edge 0 and an empty FIFO, CAPTURE SHALL occur in cycle ACC_LEN+1 and out_valid SHALL rise in cycle ACC_LEN+2.
REQ-032 overflow SHALL clear only on reset.

Reset
REQ-033 reset low SHALL immediately force: FSM IDLE, counter 0, FIFO empty, out_valid 0, out_data 0, busy 0, sat_flag 0, overflow 0.
REQ-034 Reset asserted mid-window SHALL discard the window, and no result SHALL be produced after release.
REQ-035 After reset release, start SHALL be honoured from the first rising edge.

Configuration
REQ-036 Macro DRAIN_RELU_EN defined: negative acc_in SHALL be replaced by 0 before shifting, so results are never negative and never clamp low.
REQ-037 Macro DRAIN_RELU_EN undefined: no ReLU; signed results pass through per REQ-021.

Verification
REQ-038 Basic latency: ACC_LEN=16, acc_in=0x0000123, shift 0, start once -> out_valid in cycle 18, out_data=0x0123, sat_flag=0.
REQ-039 Saturation: acc_in=0x0100000, shift 2 -> out_data=0x7FFF, sat_flag pulses; acc_in=0xF000000, shift 0 -> 0x8000 without DRAIN_RELU_EN, 0x0000 with it.
REQ-040 Back-to-back and FIFO limits: out_ready=0, start re-asserted in every CAPTURE for 5 windows -> 4 entries held, overflow=1 after the 5th, and out_data is the 1st result.
REQ-041 Full push/pop: FIFO full, out_ready=1 in a CAPTURE cycle -> push accepted, no overflow, occupancy stays 4.
REQ-042 Reset mid-operation: reset low in COUNT cycle 5, released 2 cycles later -> busy=0, out_valid=0, and no result ever appears.
REQ-043 Ignored start: start pulsed during COUNT -> exactly one result is produced, at the normal latency.
